// File: rtl/interrupt_controller.sv
// Requester side of the PC unit's interrupt interface: edge-captured prioritized
// requests, in-service arbitration, 3-deep EPC stack and ERET handling.
module interrupt_controller #(
  parameter int unsigned GUARD_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  irqRequest,
  input  logic [2:0]  irqMask,
  input  logic        globalEnable,
  input  logic        enable,
  input  logic        bubble,
  input  logic [31:0] pc,
  input  logic        eret,
  output logic        interrupted,
  output logic        interruptReturned,
  output logic [2:0]  interrupt,
  output logic [31:0] epc,
  output logic [2:0]  pending,
  output logic [2:0]  inService,
  output logic [1:0]  depth,
  output logic        spuriousEret,
  output logic [31:0] interruptCount
);

  localparam int unsigned GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  typedef enum logic {READY, GUARD} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [2:0]    prevReq_q;
  logic [2:0]    pending_q, pending_d;
  logic [2:0]    inService_q, inService_d;
  logic [1:0]    depth_q, depth_d;
  logic          spurious_q, spurious_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   stack_q [3];

  logic       adv;
  logic [2:0] rise;
  logic [2:0] cand;
  logic [2:0] topService;
  logic       eligible;
  logic       eretValid;
  logic       take;

  function automatic logic [2:0] top_bit(input logic [2:0] v);
    if (v[2])      return 3'b100;
    else if (v[1]) return 3'b010;
    else if (v[0]) return 3'b001;
    return 3'b000;
  endfunction

  // One-hot levels order numerically, so "strictly above" is a plain compare.
  always_comb begin
    adv        = enable & ~bubble;
    rise       = irqRequest & ~prevReq_q;
    cand       = top_bit(pending_q & ~irqMask);
    topService = top_bit(inService_q);
    eligible   = (cand != 3'b000) && (cand > topService);
    eretValid  = eret && adv && (depth_q != 2'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= READY;
      guard_q     <= '0;
      prevReq_q   <= irqRequest;
      pending_q   <= '0;
      inService_q <= '0;
      depth_q     <= '0;
      spurious_q  <= 1'b0;
      count_q     <= '0;
      for (int unsigned i = 0; i < 3; i++) stack_q[i] <= RESET_PC;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      prevReq_q   <= irqRequest;
      pending_q   <= pending_d;
      inService_q <= inService_d;
      depth_q     <= depth_d;
      spurious_q  <= spurious_d;
      count_q     <= count_d;
      if (take) stack_q[depth_q] <= pc;
    end
  end

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    if (take || eretValid) begin
      if (GUARD_CYCLES == 0) begin
        state_d = READY;
      end else begin
        state_d = GUARD;
        guard_d = GW'(GUARD_CYCLES);
      end
    end else if (state_q == GUARD && adv) begin
      guard_d = guard_q - GW'(1);
      if (guard_d == '0) state_d = READY;
    end
  end

  // ERET takes precedence over a simultaneous take; the request stays pending.
  always_comb begin
    take              = (state_q == READY) && adv && globalEnable && eligible && !eretValid;
    interrupted       = take;
    interrupt         = take ? cand : 3'b000;
    interruptReturned = eretValid;
  end

  // A new rise is OR-ed in after the grant clear, so set wins over clear.
  always_comb begin
    pending_d   = (pending_q & ~(take ? cand : 3'b000)) | rise;
    inService_d = inService_q;
    depth_d     = depth_q;
    count_d     = count_q;
    spurious_d  = spurious_q | (eret && adv && (depth_q == 2'd0));
    if (eretValid) begin
      inService_d = inService_q & ~topService;
      depth_d     = depth_q - 2'd1;
    end else if (take) begin
      inService_d = inService_q | cand;
      depth_d     = depth_q + 2'd1;
      count_d     = count_q + 32'd1;
    end
  end

  always_comb begin
    epc            = (depth_q == 2'd0) ? RESET_PC : stack_q[depth_q - 2'd1];
    pending        = pending_q;
    inService      = inService_q;
    depth          = depth_q;
    spuriousEret   = spurious_q;
    interruptCount = count_q;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expectations are queued as stimulus
// is applied and compared against the DUT outputs at each sample point.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  irqRequest, irqMask;
  logic        globalEnable, enable, bubble, eret;
  logic [31:0] pc;
  logic        interrupted, interruptReturned, spuriousEret;
  logic [2:0]  interrupt, pending, inService;
  logic [1:0]  depth;
  logic [31:0] epc, interruptCount;

  localparam logic [31:0] RPC = 32'h0000_0100;

  interrupt_controller #(.GUARD_CYCLES(2), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .irqRequest(irqRequest), .irqMask(irqMask),
    .globalEnable(globalEnable), .enable(enable), .bubble(bubble), .pc(pc),
    .eret(eret), .interrupted(interrupted), .interruptReturned(interruptReturned),
    .interrupt(interrupt), .epc(epc), .pending(pending), .inService(inService),
    .depth(depth), .spuriousEret(spuriousEret), .interruptCount(interruptCount)
  );

  always #5 clock = ~clock;

  typedef enum {S_INTD, S_INT, S_RET, S_EPC, S_PEND, S_INSV, S_DEPTH, S_SPUR, S_CNT} sig_e;
  typedef struct {string tag; sig_e sel; logic [31:0] exp;} exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] obs(input sig_e s);
    case (s)
      S_INTD:  return 32'(interrupted);
      S_INT:   return 32'(interrupt);
      S_RET:   return 32'(interruptReturned);
      S_EPC:   return epc;
      S_PEND:  return 32'(pending);
      S_INSV:  return 32'(inService);
      S_DEPTH: return 32'(depth);
      S_SPUR:  return 32'(spuriousEret);
      S_CNT:   return interruptCount;
      default: return '0;
    endcase
  endfunction

  task automatic push_exp(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock)
    if (!reset) assert (!(interrupted && depth == 2'd3))
      else $error("FAIL overflow take at depth 3");

  initial begin
    reset = 1'b1; irqRequest = '0; irqMask = '0; globalEnable = 1'b1;
    enable = 1'b1; bubble = 1'b0; eret = 1'b0; pc = 32'h40;
    cyc(); cyc();
    reset = 1'b0;
    push_exp("rst_depth", S_DEPTH, 0); push_exp("rst_epc", S_EPC, RPC);
    push_exp("rst_pend", S_PEND, 0);   push_exp("rst_insv", S_INSV, 0);
    push_exp("rst_cnt", S_CNT, 0);     push_exp("rst_spur", S_SPUR, 0);
    push_exp("rst_intd", S_INTD, 0);   push_exp("rst_ret", S_RET, 0);
    score();

    // single take at pc 0x40
    irqRequest = 3'b001; push_exp("t1_noearly", S_INTD, 0); score(); cyc();
    irqRequest = 3'b000;
    push_exp("t1_pend", S_PEND, 1); push_exp("t1_intd", S_INTD, 1); push_exp("t1_int", S_INT, 3'b001);
    score(); cyc();
    push_exp("t1_depth", S_DEPTH, 1); push_exp("t1_epc", S_EPC, 32'h40);
    push_exp("t1_pclr", S_PEND, 0);   push_exp("t1_cnt", S_CNT, 1); push_exp("t1_insv", S_INSV, 3'b001);
    score();

    // guard: 100 pending but blocked for two advancing cycles, then nested take
    irqRequest = 3'b100; push_exp("g_blk1", S_INTD, 0); score(); cyc();
    irqRequest = 3'b000; push_exp("g_blk2", S_INTD, 0); push_exp("g_pend", S_PEND, 3'b100); score(); cyc();
    pc = 32'h104; push_exp("n_intd", S_INTD, 1); push_exp("n_int", S_INT, 3'b100); score(); cyc();
    push_exp("n_depth", S_DEPTH, 2); push_exp("n_epc", S_EPC, 32'h104);
    push_exp("n_insv", S_INSV, 3'b101); push_exp("n_cnt", S_CNT, 2); score();

    // ERET from nested handler (honoured during guard)
    eret = 1'b1; push_exp("r_ret", S_RET, 1); push_exp("r_epc", S_EPC, 32'h104); push_exp("r_intd", S_INTD, 0);
    score(); cyc();
    eret = 1'b0;
    push_exp("r_depth", S_DEPTH, 1); push_exp("r_insv", S_INSV, 3'b001); push_exp("r_epc2", S_EPC, 32'h40);
    score(); cyc(); cyc();
    eret = 1'b1; push_exp("r2_ret", S_RET, 1); push_exp("r2_epc", S_EPC, 32'h40); score(); cyc();
    eret = 1'b0; push_exp("r2_depth", S_DEPTH, 0); push_exp("r2_epc_rst", S_EPC, RPC); push_exp("r2_insv", S_INSV, 0);
    score(); cyc(); cyc();

    // mask: 011 with 001 masked grants 010
    irqMask = 3'b001; irqRequest = 3'b011; pc = 32'h200; score(); cyc();
    irqRequest = 3'b000;
    push_exp("m_intd", S_INTD, 1); push_exp("m_int", S_INT, 3'b010); push_exp("m_pend", S_PEND, 3'b011);
    score(); cyc();
    push_exp("m_pend2", S_PEND, 3'b001); push_exp("m_insv", S_INSV, 3'b010); push_exp("m_cnt", S_CNT, 3);
    push_exp("m_epc", S_EPC, 32'h200); score();
    irqRequest = 3'b010; cyc();
    irqRequest = 3'b000; push_exp("p_guard", S_INTD, 0); push_exp("p_pend", S_PEND, 3'b011); score(); cyc();
    push_exp("p_same_lvl", S_INTD, 0); score();
    irqMask = 3'b000; push_exp("p_unmask", S_INTD, 0); push_exp("p_int0", S_INT, 0); score(); cyc();
    eret = 1'b1; push_exp("p_ret", S_RET, 1); push_exp("p_repc", S_EPC, 32'h200); score(); cyc();
    eret = 1'b0; pc = 32'h300;
    push_exp("p_depth0", S_DEPTH, 0); push_exp("p_insv0", S_INSV, 0); push_exp("p_g1", S_INTD, 0); score(); cyc();
    push_exp("p_g2", S_INTD, 0); score(); cyc();
    push_exp("p_take010", S_INTD, 1); push_exp("p_int010", S_INT, 3'b010); score(); cyc();
    push_exp("p_cnt4", S_CNT, 4); push_exp("p_pend001", S_PEND, 3'b001); push_exp("p_epc300", S_EPC, 32'h300);
    score(); cyc(); cyc();
    push_exp("p_low_blk", S_INTD, 0); score();
    eret = 1'b1; push_exp("p_ret2", S_RET, 1); score(); cyc();
    eret = 1'b0; pc = 32'h400; cyc(); cyc();
    push_exp("p_take001", S_INTD, 1); push_exp("p_int001", S_INT, 3'b001); score(); cyc();
    push_exp("p_cnt5", S_CNT, 5); push_exp("p_pend0", S_PEND, 0); push_exp("p_epc400", S_EPC, 32'h400); score();

    // simultaneous ERET and eligible take: ERET wins
    irqRequest = 3'b100; cyc();
    irqRequest = 3'b000; cyc();
    eret = 1'b1; push_exp("s_ret", S_RET, 1); push_exp("s_intd", S_INTD, 0); score(); cyc();
    eret = 1'b0; push_exp("s_pend", S_PEND, 3'b100); push_exp("s_depth", S_DEPTH, 0); push_exp("s_g1", S_INTD, 0);
    score(); cyc();
    push_exp("s_g2", S_INTD, 0); score(); cyc();

    // bubble stalls the take
    bubble = 1'b1; push_exp("b_stall1", S_INTD, 0); score(); cyc();
    push_exp("b_stall2", S_INTD, 0); push_exp("b_pend", S_PEND, 3'b100); score(); cyc();
    bubble = 1'b0; pc = 32'h500; push_exp("b_take", S_INTD, 1); push_exp("b_int", S_INT, 3'b100); score(); cyc();
    push_exp("b_cnt", S_CNT, 6); push_exp("b_depth", S_DEPTH, 1); push_exp("b_epc", S_EPC, 32'h500); score();

    // spurious ERET at depth 0
    eret = 1'b1; push_exp("e_ret", S_RET, 1); score(); cyc();
    push_exp("e_depth0", S_DEPTH, 0); push_exp("e_noret", S_RET, 0); push_exp("e_spur_pre", S_SPUR, 0); score(); cyc();
    eret = 1'b0; push_exp("e_spur", S_SPUR, 1); push_exp("e_epc", S_EPC, RPC); score();

    // reset mid-handler with a line held high through reset
    irqRequest = 3'b001; pc = 32'h600; cyc();
    irqRequest = 3'b000; push_exp("x_take1", S_INT, 3'b001); score(); cyc();
    irqRequest = 3'b010; cyc();
    irqRequest = 3'b000; cyc();
    pc = 32'h700; push_exp("x_take2", S_INT, 3'b010); score(); cyc();
    irqRequest = 3'b001; cyc();
    irqRequest = 3'b000; push_exp("x_pend", S_PEND, 3'b001); push_exp("x_depth", S_DEPTH, 2);
    push_exp("x_cnt", S_CNT, 8); score();
    irqRequest = 3'b100; reset = 1'b1; cyc(); cyc();
    reset = 1'b0;
    push_exp("x_depth0", S_DEPTH, 0); push_exp("x_epc", S_EPC, RPC); push_exp("x_pend0", S_PEND, 0);
    push_exp("x_insv0", S_INSV, 0);   push_exp("x_cnt0", S_CNT, 0);  push_exp("x_spur0", S_SPUR, 0);
    push_exp("x_intd0", S_INTD, 0);   score(); cyc(); cyc();
    push_exp("x_held_pend", S_PEND, 0); push_exp("x_held_intd", S_INTD, 0); score();
    irqRequest = 3'b000; cyc();
    irqRequest = 3'b100; cyc();
    push_exp("x_rerise", S_PEND, 3'b100); score();
    irqRequest = 3'b000; push_exp("x_retake", S_INTD, 1); push_exp("x_retake_int", S_INT, 3'b100); score();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Requester side of the PC unit's interrupt interface.
- Latches three prioritized request lines, arbitrates against the in-service level, and issues `interrupted` / `interrupt` / `epc` to the PC unit.
- Keeps a 3-deep EPC stack for nested handlers and answers ERET with `interruptReturned` plus the saved EPC.
- Sits beside the PC unit and is gated by the same pipeline enable/bubble qualifiers.

Parameters:
- GUARD_CYCLES, 2: advancing cycles after a take or return during which no new take is allowed (pipeline refill).
- RESET_PC, 32'h0: value driven on `epc` when the stack is empty.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- irqRequest  input  3  request lines; bit2 highest priority, bit0 lowest
- irqMask  input  3  1 = line masked
- globalEnable  input  1  0 = no new takes (ERET still served)
- enable  input  1  pipeline advance (same signal the PC unit uses)
- bubble  input  1  stall bubble (same signal the PC unit uses)
- pc  input  32  address of next unexecuted instruction (return address)
- eret  input  1  ERET instruction committing this cycle
- interrupted  output  1  take request to the PC unit
- interruptReturned  output  1  return request to the PC unit
- interrupt  output  3  one-hot granted level; 000 when none
- epc  output  32  top of EPC stack
- pending  output  3  pending latch contents
- inService  output  3  levels currently being serviced
- depth  output  2  EPC stack occupancy, 0..3
- spuriousEret  output  1  sticky flag: ERET seen with empty stack
- interruptCount  output  32  number of takes since reset

Behaviour:
- `adv = enable && !bubble`. All state updates happen on posedge `clock`.
- **Reset:**
  - pending, inService, depth, interruptCount, spuriousEret and the guard counter are cleared.
  - Stack entries are set to RESET_PC.
  - `prevReq <= irqRequest`, so a line held high through reset does not fire.
  - Reset has priority over every other event in the same cycle.
- **Edge capture:**
  - `prevReq <= irqRequest` every cycle.
  - A rise (`irqRequest & ~prevReq`) sets the pending bit.
  - A repeated rise while the bit is already pending merges into it.
  - A rise in the same cycle as that level's grant re-sets the bit; set wins over clear.
- **Masking:** a masked pending bit stays pending. It becomes eligible once unmasked.
- **Arbitration (combinational):**
  - `cand` = highest set bit of `pending & ~irqMask`.
  - `cand` is eligible only if its level is strictly above the highest set bit of `inService` (none counts as lowest).
- **FSM states:** READY, GUARD.
- **Take condition:** `take = READY && adv && globalEnable && eligible && !eretValid`, where `eretValid = eret && adv && depth != 0`.
  - `interrupted = take`, combinational in the same cycle.
  - `interrupt = take ? onehot(cand) : 3'b000`. The PC unit vectors 100 -> 0x0c, 010 -> 0x08, 001 -> 0x04.
  - On the take edge: push `pc`, set the inService bit, clear the pending bit, increment interruptCount, and go to GUARD with `guard = GUARD_CYCLES`.
- **ERET handling:**
  - `interruptReturned = eretValid`, in any state.
  - `epc` = top entry; it is already stable before the cycle because it is register-driven.
  - On the ERET edge: pop, clear the highest inService bit, and go to GUARD with `guard = GUARD_CYCLES`.
  - ERET with `depth == 0` drives no response and sets spuriousEret.
- **Guard:** GUARD decrements only on `adv` cycles and returns to READY when it reaches 0. A stall extends the guard. ERET is still honoured in GUARD.
- **Simultaneous take and ERET:** ERET wins and the take is deferred; pending is kept.
- **Stack limits:** `depth == 3` implies all levels are in service, so no further take is eligible. Overflow is therefore impossible; the bench checks it with an assertion.
- `epc` is RESET_PC when `depth == 0`.
- When `adv = 0`, nothing is taken or returned. Edge capture continues.

Test Plan:
1. Single take, GUARD_CYCLES=2, `pc`=0x40:
   - Pulse irqRequest=001 -> next adv cycle `interrupted`=1, `interrupt`=001.
   - After the edge: depth=1, `epc`=0x40, pending=000, interruptCount=1.
   - No take is possible for 2 adv cycles.
2. Nesting:
   - In service 001 at pc 0x40, raise 100 at pc 0x104 -> take with `interrupt`=100, depth=2, `epc`=0x104.
   - ERET -> `interruptReturned`=1 with `epc`=0x104; after the edge, depth=1, inService=001, `epc`=0x40.
3. Priority and mask:
   - Raise 010 while 010 is in service -> no take.
   - Raise 011 with irqMask=001 from idle -> grant 010 first; 001 stays pending and is granted only after unmask and ERET.
4. Simultaneous events:
   - ERET and an eligible pending 100 in the same cycle -> `interruptReturned`=1, `interrupted`=0.
   - 100 is taken after the guard expires.
5. Stalls and spurious ERET:
   - bubble=1 during a pending eligible request -> `interrupted`=0 until bubble drops.
   - ERET at depth 0 -> no `interruptReturned`, spuriousEret=1.
6. Reset mid-handler:
   - depth=2, pending=001, irqRequest held at 100 -> after reset all outputs are 0, `epc`=RESET_PC.
   - The held 100 line stays quiet; no pending bit is set until it falls and rises again.
